// File: rtl/divider_sequencer.sv
// divider_sequencer: plays a register-programmed table of (divide value,
// duration) steps into the div_num input of an N+1 frequency divider.
// Step durations are counted in ticks from a programmable prescaler.
// Optional feature: define DIVIDER_SEQ_GLIDE_EN to make div_num slide by one
// count per tick toward each non-rest target instead of jumping to it.
module divider_sequencer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DUR_W  = 8,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [10:0]       wr_div,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [AW-1:0]     len,
  input  logic [TICK_W-1:0] tick_period,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [10:0]       div_num,
  output logic              gate,
  output logic              busy,
  output logic [AW-1:0]     step_idx,
  output logic              step_pulse,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t             state;
  logic [10:0]        mem_div [DEPTH];
  logic [DUR_W-1:0]   mem_dur [DEPTH];
  logic [10:0]        ld_div;
  logic [DUR_W-1:0]   ld_dur;
  logic [DUR_W-1:0]   rd_dur_p1;
  logic [DUR_W-1:0]   dur_last;
  logic [TICK_W-1:0]  presc;
  logic [DUR_W-1:0]   tick_cnt;
  logic               tick;
  logic               step_end;

`ifdef DIVIDER_SEQ_GLIDE_EN
  logic [10:0]        rd_div_p1;

  // Move one count toward the target, or stay put once it is reached.
  function automatic logic [10:0] glide_step(input logic [10:0] cur,
                                             input logic [10:0] tgt);
    if (cur < tgt)      glide_step = cur + 11'd1;
    else if (cur > tgt) glide_step = cur - 11'd1;
    else                glide_step = cur;
  endfunction
`endif

  // Stretch a zero duration to one tick so every step has a defined end.
  function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
    dur_eff = (d == '0) ? DUR_W'(1) : d;
  endfunction

  assign ld_div   = mem_div[step_idx];
  assign ld_dur   = mem_dur[step_idx];
  assign dur_last = rd_dur_p1 - DUR_W'(1);
  assign tick     = (presc >= tick_period);
  assign step_end = tick && (tick_cnt == dur_last);

  // Table storage: writable at any time, never reset; a same-edge read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_div[wr_addr] <= wr_div;
      mem_dur[wr_addr] <= wr_dur;
    end
  end

  // Registered table read, captured at the end of the LOAD cycle.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      rd_dur_p1 <= dur_eff(ld_dur);
`ifdef DIVIDER_SEQ_GLIDE_EN
      rd_div_p1 <= ld_div;
`endif
    end
  end

  // Sequencer FSM with prescaler, tick counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      div_num    <= '0;
      gate       <= 1'b0;
      busy       <= 1'b0;
      step_idx   <= '0;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      presc      <= '0;
      tick_cnt   <= '0;
    end else begin
      step_pulse <= 1'b0;
      done       <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a simultaneous start.
        state <= S_IDLE;
        busy  <= 1'b0;
        gate  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            gate <= 1'b0;
            if (start) begin
              step_idx <= '0;
              busy     <= 1'b1;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            presc      <= '0;
            tick_cnt   <= '0;
            step_pulse <= 1'b1;
            gate       <= (ld_div != 11'd0);
`ifndef DIVIDER_SEQ_GLIDE_EN
            // A rest leaves the divider on its previous value.
            if (ld_div != 11'd0) div_num <= ld_div;
`endif
            state      <= S_PLAY;
          end
          S_PLAY: begin
            if (tick) begin
              presc <= '0;
`ifdef DIVIDER_SEQ_GLIDE_EN
              if (rd_div_p1 != 11'd0) div_num <= glide_step(div_num, rd_div_p1);
`endif
              if (step_end) begin
                tick_cnt <= '0;
                if (step_idx < len) begin
                  step_idx <= step_idx + AW'(1);
                  state    <= S_LOAD;
                end else if (loop) begin
                  step_idx <= '0;
                  state    <= S_LOAD;
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  gate  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt + DUR_W'(1);
              end
            end else begin
              presc <= presc + TICK_W'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            gate  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer (default build) with a step scoreboard.
module tb_divider_sequencer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [10:0] wr_div;
  logic [7:0]  wr_dur;
  logic [3:0]  len;
  logic [15:0] tick_period;
  logic        loop;
  logic        start;
  logic        stop;
  logic [10:0] div_num;
  logic        gate;
  logic        busy;
  logic [3:0]  step_idx;
  logic        step_pulse;
  logic        done;

  typedef struct packed {
    logic [10:0] div;
    logic        gate;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  divider_sequencer #(.DEPTH(16), .AW(4), .DUR_W(8), .TICK_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_div(wr_div),
    .wr_dur(wr_dur), .len(len), .tick_period(tick_period), .loop(loop),
    .start(start), .stop(stop), .div_num(div_num), .gate(gate), .busy(busy),
    .step_idx(step_idx), .step_pulse(step_pulse), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [10:0] d, input logic [7:0] u);
    wr_en = 1'b1; wr_addr = a; wr_div = d; wr_dur = u;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic push(input logic [10:0] d, input logic g, input logic [3:0] i);
    exp_t e;
    e.div = d; e.gate = g; e.idx = i;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each first PLAY cycle must match the next expected step.
  always @(negedge clk) begin
    if (!rst && step_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: unexpected step div=%0d idx=%0d", div_num, step_idx);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_div", 32'(div_num), 32'(mon_e.div));
        check("sb_gate", 32'(gate), 32'(mon_e.gate));
        check("sb_idx", 32'(step_idx), 32'(mon_e.idx));
      end
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_div = '0; wr_dur = '0;
    len = '0; tick_period = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(2);
    check("rst_div", 32'(div_num), 0);
    check("rst_gate", 32'(gate), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(step_idx), 0);
    check("rst_pulse", 32'(step_pulse), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    cyc(1);

    // Basic step: (100,2), tick_period 3
    write_entry(4'd0, 11'd100, 8'd2);
    len = 4'd0; loop = 1'b0; tick_period = 16'd3;
    push(11'd100, 1'b1, 4'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("b_busy_load", 32'(busy), 1);
    check("b_pulse_load", 32'(step_pulse), 0);
    cyc(1);
    check("b_div", 32'(div_num), 100);
    check("b_pulse", 32'(step_pulse), 1);
    check("b_gate", 32'(gate), 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("b_gate_hold", 32'(gate), 1);
      check("b_done_early", 32'(done), 0);
    end
    cyc(1);
    check("b_done", 32'(done), 1);
    check("b_busy_fall", 32'(busy), 0);
    check("b_gate_off", 32'(gate), 0);
    check("b_div_hold", 32'(div_num), 100);
    cyc(1);
    check("b_done_once", 32'(done), 0);

    // Three-step looping sequence, tick_period 0
    write_entry(4'd0, 11'd10, 8'd1);
    write_entry(4'd1, 11'd0, 8'd1);
    write_entry(4'd2, 11'd20, 8'd1);
    len = 4'd2; loop = 1'b1; tick_period = 16'd0;
    for (int p = 0; p < 2; p++) begin
      push(11'd10, 1'b1, 4'd0);
      push(11'd10, 1'b0, 4'd1);
      push(11'd20, 1'b1, 4'd2);
    end
    push(11'd10, 1'b1, 4'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    for (int s = 0; s < 6; s++) begin
      check("l_pulse", 32'(step_pulse), 1);
      check("l_div", 32'(div_num), (s % 3 == 2) ? 20 : 10);
      check("l_gate", 32'(gate), (s % 3 == 1) ? 0 : 1);
      cyc(1);
      check("l_load_pulse", 32'(step_pulse), 0);
      check("l_busy", 32'(busy), 1);
      cyc(1);
    end
    check("l_wrap_div", 32'(div_num), 10);
    check("l_wrap_idx", 32'(step_idx), 0);

    // Stop and start together mid-PLAY
    stop = 1'b1; start = 1'b1;
    cyc(1);
    stop = 1'b0; start = 1'b0;
    check("s_busy", 32'(busy), 0);
    check("s_gate", 32'(gate), 0);
    check("s_div_hold", 32'(div_num), 10);
    check("s_no_done", 32'(done), 0);
    cyc(1);
    check("s_no_restart", 32'(busy), 0);
    check("s_no_pulse", 32'(step_pulse), 0);
    check("s_done_cnt", 32'(done_cnt), 1);

    // Write during playback
    len = 4'd1; loop = 1'b0; tick_period = 16'd1;
    write_entry(4'd0, 11'd30, 8'd2);
    write_entry(4'd1, 11'd40, 8'd2);
    push(11'd30, 1'b1, 4'd0);
    push(11'd50, 1'b1, 4'd1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    wr_en = 1'b1; wr_addr = 4'd1; wr_div = 11'd50; wr_dur = 8'd2;
    cyc(1);
    wr_en = 1'b0;
    cyc(7);
    check("w1_done", 32'(done), 1);
    check("w1_div", 32'(div_num), 50);
    check("w1_idx", 32'(step_idx), 1);

    push(11'd30, 1'b1, 4'd0);
    push(11'd50, 1'b1, 4'd1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    check("w2_load_idx", 32'(step_idx), 1);
    check("w2_load_pulse", 32'(step_pulse), 0);
    wr_en = 1'b1; wr_addr = 4'd1; wr_div = 11'd60; wr_dur = 8'd2;
    cyc(1);
    wr_en = 1'b0;
    check("w2_old_div", 32'(div_num), 50);
    cyc(4);
    check("w2_done", 32'(done), 1);

    push(11'd30, 1'b1, 4'd0);
    push(11'd60, 1'b1, 4'd1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(6);
    check("w3_new_div", 32'(div_num), 60);
    cyc(4);
    check("w3_done", 32'(done), 1);

    // Reset mid-PLAY, then replay from index 0
    len = 4'd0; tick_period = 16'd3;
    push(11'd30, 1'b1, 4'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("r_gate_before", 32'(gate), 1);
    rst = 1'b1;
    #1;
    check("r_div", 32'(div_num), 0);
    check("r_gate", 32'(gate), 0);
    check("r_busy", 32'(busy), 0);
    check("r_idx", 32'(step_idx), 0);
    check("r_pulse", 32'(step_pulse), 0);
    check("r_done", 32'(done), 0);
    cyc(1);
    rst = 1'b0;
    push(11'd30, 1'b1, 4'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("r2_busy", 32'(busy), 1);
    check("r2_idx", 32'(step_idx), 0);
    cyc(1);
    check("r2_div", 32'(div_num), 30);
    cyc(8);
    check("r2_done", 32'(done), 1);

    // Zero duration plays as one tick
    write_entry(4'd0, 11'd77, 8'd0);
    len = 4'd0; tick_period = 16'd2;
    push(11'd77, 1'b1, 4'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    check("z_busy", 32'(busy), 1);
    check("z_gate", 32'(gate), 1);
    cyc(1);
    check("z_done", 32'(done), 1);
    check("z_busy_fall", 32'(busy), 0);

    // Without glide the target is applied at once and held for the step
    write_entry(4'd0, 11'd10, 8'd1);
    write_entry(4'd1, 11'd14, 8'd8);
    len = 4'd1; tick_period = 16'd1;
    push(11'd10, 1'b1, 4'd0);
    push(11'd14, 1'b1, 4'd1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check("j_div", 32'(div_num), 14);
    check("j_pulse", 32'(step_pulse), 1);
    cyc(7);
    check("j_div_mid", 32'(div_num), 14);
    cyc(9);
    check("j_done", 32'(done), 1);
    check("j_div_end", 32'(div_num), 14);

    cyc(2);
    check("done_total", 32'(done_cnt), 7);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_sequencer.md
# divider_sequencer

Step sequencer that drives the `div_num` input of the variable N+1 frequency divider. It plays a register-programmed table of (divide value, duration) entries, so the synthesizer output walks through a note sequence without CPU involvement. The block holds the table, times each step with a programmable tick prescaler, and exposes a start/stop control plus status and step strobes.

## Interface
- `DEPTH`, 16: table entries; power of two.
- `AW`, 4: table address width; log2(`DEPTH`).
- `DUR_W`, 8: duration field width, in ticks.
- `TICK_W`, 16: prescaler width.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_div`  in  11  divide value to store; 0 marks a rest.
- `wr_dur`  in  DUR_W  duration to store, in ticks; 0 is treated as 1.
- `len`  in  AW  index of the last step.
- `tick_period`  in  TICK_W  clocks per tick, minus 1.
- `loop`  in  1  on 1, restart at index 0 after step `len`.
- `start`  in  1  begin playback at index 0; level-sampled.
- `stop`  in  1  abort playback.
- `div_num`  out  11  to the divider's `div_num`.
- `gate`  out  1  high while a non-rest step plays; mute enable.
- `busy`  out  1  high outside IDLE.
- `step_idx`  out  AW  index of the current or last step.
- `step_pulse`  out  1  one-cycle strobe on each step's first PLAY cycle.
- `done`  out  1  one-cycle strobe at the end of a non-looping sequence.

## Operation
- **Table**
  - `DEPTH` x (11+`DUR_W`) registers.
  - Written when `wr_en`=1, at any time.
  - Read is registered.
  - A write and a read of the same address in the same cycle return the old data.
  - The table is not reset.
- **FSM states:** IDLE, LOAD, PLAY.
- **IDLE**
  - `busy`=0 and `gate`=0.
  - `start`=1 sets `step_idx`=0 and moves to LOAD.
- **LOAD** (1 cycle)
  - Reads entry `step_idx`.
  - Clears the prescaler and the tick counter.
  - Moves to PLAY.
- **PLAY**
  - First cycle: `step_pulse`=1.
  - If the entry's div != 0: `div_num` takes the entry's div and `gate`=1.
  - If the entry's div = 0 (rest): `div_num` holds and `gate`=0.
  - The prescaler counts 0..`tick_period`; one tick occurs on the wrap.
  - After max(dur,1) ticks the step ends:
    - `step_idx` < `len`: increment `step_idx` and go to LOAD.
    - `step_idx` >= `len` with `loop`=1: `step_idx`=0 and go to LOAD.
    - `step_idx` >= `len` with `loop`=0: go to IDLE with `done`=1 and `gate`=0; `div_num` holds.
- **stop**
  - From any state: IDLE on the next cycle, `gate`=0, no `done` pulse, `div_num` holds.
  - `stop` takes priority over a simultaneous `start`.
- `start` while `busy` is ignored.
- `len` and `loop` are sampled only at step end, so changing them mid-run takes effect at the next boundary.
- Reset forces IDLE with outputs: `div_num`=0, `gate`=0, `busy`=0, `step_idx`=0, `step_pulse`=0, `done`=0. The prescaler is also cleared.

## Timing
- `start` high at cycle 0 -> LOAD at cycle 1 -> PLAY at cycle 2, with `div_num` valid and `step_pulse`=1.
- Each step occupies 1 + max(dur,1)·(`tick_period`+1) cycles, LOAD included.
- `busy` rises the cycle after `start` is accepted.
- `busy` falls in the same cycle that `done` pulses.
- `div_num` changes only on the first PLAY cycle, or on ticks when glide is enabled. The divider sees a stable value for whole steps.
- A table write takes effect for any LOAD at least one cycle later.

## Configuration
- **`DIVIDER_SEQ_GLIDE_EN` defined:**
  - On a non-rest step, `div_num` moves by 1 toward the entry's div on each tick, starting at the first tick.
  - Once `div_num` equals the target it stops moving.
  - If the target is not reached before step end, the next step glides from the current value.
  - `step_pulse` and `gate` timing are unchanged.
- **Not defined:** `div_num` jumps to the target on the first PLAY cycle. The glide logic is absent.

## Test plan
- **Basic step:** write entry0 = (div 100, dur 2), `len`=0, `loop`=0, `tick_period`=3, pulse `start` -> `div_num`=100 at cycle 2. Expect `step_pulse` at cycle 2, `gate` high for 8 cycles, `done` at cycle 10, `busy` low from cycle 10.
- **Three-step sequence with loop:** entries (10,1), (0,1), (20,1), `len`=2, `loop`=1, `tick_period`=0 -> `div_num` = 10, then holds 10 with `gate`=0, then 20, then 10 again. Each step lasts 2 cycles and no `done` pulse occurs.
- **Stop and start in the same cycle mid-PLAY:** -> IDLE on the next cycle with `gate`=0 and `div_num` holding its value. No `done` pulse, and no restart.
- **Write during playback:** overwrite entry1 while entry0 plays -> entry1 plays the new value. A write coinciding with entry1's LOAD cycle plays the old value.
- **Reset mid-PLAY** -> all outputs at reset values immediately, `busy`=0; a later `start` replays from index 0.
- **Glide (`DIVIDER_SEQ_GLIDE_EN`):** `div_num` at 10, next entry (14,8), `tick_period`=1 -> `div_num` steps 11, 12, 13, 14 on ticks 1-4, then holds at 14.
